pwm_controller: RTL

PWM_CONTROLLER -- requirements
Module: pwm_controller

---
 rtl/pwm_controller.sv | 115 +++++++++++
 1 files changed

// File: rtl/pwm_controller.sv
// 16-channel PWM controller fed by single-cycle register writes from an SPI stage.
// Duty is double-buffered (shadow -> active at period wrap); enables apply immediately.
module pwm_controller #(
  parameter int unsigned MAX_ADDR = 4,
  parameter int unsigned CLK_DIV  = 3000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_err,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic       period_start
);

  localparam logic [15:0] PRESC_LAST = 16'(CLK_DIV - 1);

  logic [15:0] en_out_q, en_out_d;
  logic [15:0] en_pwm_q, en_pwm_d;
  logic [7:0]  duty_shadow_q, duty_shadow_d;
  logic [7:0]  duty_active_q, duty_active_d;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [15:0] out_q, out_d;
  logic        wr_err_q, wr_err_d;
  logic        period_start_q, period_start_d;

  logic        addr_ok_s;
  logic        tick_s;
  logic        wrap_s;
  logic        pwm_sig_s;

  assign addr_ok_s = ({25'd0, wr_addr} <= MAX_ADDR);
  assign tick_s    = (presc_q == PRESC_LAST);
  assign wrap_s    = tick_s && (pwm_cnt_q == 8'hFF);
  // Full-scale duty must stay high across the cnt=255 slot, so it is special-cased.
  assign pwm_sig_s = (duty_active_q == 8'hFF) ? 1'b1 : (pwm_cnt_q < duty_active_q);

  assign uo_out       = out_q[7:0];
  assign uio_out      = out_q[15:8];
  assign wr_err       = wr_err_q;
  assign period_start = period_start_q;

  // Next-state: register writes, free-running timebase, duty handover and output mux.
  always_comb begin
    en_out_d      = en_out_q;
    en_pwm_d      = en_pwm_q;
    duty_shadow_d = duty_shadow_q;
    wr_err_d      = 1'b0;

    if (wr_valid) begin
      if (addr_ok_s) begin
        case (wr_addr)
          7'h00:   en_out_d[7:0]  = wr_data;
          7'h01:   en_out_d[15:8] = wr_data;
          7'h02:   en_pwm_d[7:0]  = wr_data;
          7'h03:   en_pwm_d[15:8] = wr_data;
          7'h04:   duty_shadow_d  = wr_data;
          default: duty_shadow_d  = duty_shadow_q;
        endcase
      end else begin
        wr_err_d = 1'b1;
      end
    end else begin
      wr_err_d = 1'b0;
    end

    if (tick_s) begin
      presc_d   = 16'd0;
      pwm_cnt_d = pwm_cnt_q + 8'd1;
    end else begin
      presc_d   = presc_q + 16'd1;
      pwm_cnt_d = pwm_cnt_q;
    end

    // The pre-write shadow is used on a coincident write, since duty_shadow_q is sampled here.
    if (wrap_s) begin
      duty_active_d  = duty_shadow_q;
      period_start_d = 1'b1;
    end else begin
      duty_active_d  = duty_active_q;
      period_start_d = 1'b0;
    end

    out_d = en_out_q & (~en_pwm_q | {16{pwm_sig_s}});
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out_q       <= 16'd0;
      en_pwm_q       <= 16'd0;
      duty_shadow_q  <= 8'd0;
      duty_active_q  <= 8'd0;
      presc_q        <= 16'd0;
      pwm_cnt_q      <= 8'd0;
      out_q          <= 16'd0;
      wr_err_q       <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      en_out_q       <= en_out_d;
      en_pwm_q       <= en_pwm_d;
      duty_shadow_q  <= duty_shadow_d;
      duty_active_q  <= duty_active_d;
      presc_q        <= presc_d;
      pwm_cnt_q      <= pwm_cnt_d;
      out_q          <= out_d;
      wr_err_q       <= wr_err_d;
      period_start_q <= period_start_d;
    end
  end

endmodule
